// File: rtl/filter_ch_if.sv
// rtl/filter_ch_if.sv - sample request / result handshake bundle for filter_ch_scheduler
interface filter_ch_if #(
  parameter int NCH = 4,
  parameter int CW  = 2,
  parameter int DW  = 16
);
  logic [NCH-1:0]    req_valid;
  logic [NCH*DW-1:0] req_data;
  logic [NCH-1:0]    req_ready;
  logic [NCH-1:0]    clr_ch;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic [CW-1:0]     out_ch;
  logic              out_ready;
  logic              busy;

  modport master (
    output req_valid, req_data, clr_ch, out_ready,
    input  req_ready, out_valid, out_data, out_ch, busy
  );

  modport slave (
    input  req_valid, req_data, clr_ch, out_ready,
    output req_ready, out_valid, out_data, out_ch, busy
  );
endinterface

// File: rtl/filter_ch_scheduler.sv
// rtl/filter_ch_scheduler.sv - round-robin time-multiplexed Y[n] = X[n] + X[n-1] + Y[n-1] filter
module filter_ch_scheduler #(
  parameter int NCH = 4,
  parameter int CW  = 2,
  parameter int DW  = 16
) (
  input  logic       clk,
  input  logic       reset,
  filter_ch_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] last_grant_q, last_grant_d;
  logic [CW-1:0] g_q, g_d;
  logic [DW-1:0] x_q, x_d;
  logic [DW-1:0] xprev_q [NCH];
  logic [DW-1:0] xprev_d [NCH];
  logic [DW-1:0] yprev_q [NCH];
  logic [DW-1:0] yprev_d [NCH];
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [CW-1:0] out_ch_q, out_ch_d;

  logic          any_valid;
  logic [CW-1:0] grant;
  logic [DW-1:0] y_sum;

  // First requester after the previously granted channel, wrapping modulo NCH.
  function automatic logic [CW-1:0] rr_pick(input logic [NCH-1:0] v, input logic [CW-1:0] last);
    logic [CW-1:0] pick;
    logic [CW-1:0] idx_c;
    logic          found;
    int            idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      idx   = (int'(last) + k) % NCH;
      idx_c = CW'(idx);
      if (!found && v[idx_c]) begin
        pick  = idx_c;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    any_valid = |bus.req_valid;
    grant     = rr_pick(bus.req_valid, last_grant_q);
    y_sum     = x_q + xprev_q[g_q] + yprev_q[g_q];
  end

  assign bus.req_ready = (state_q == IDLE && any_valid) ? (NCH'(1) << grant) : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.busy      = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    g_d          = g_q;
    x_d          = x_q;
    xprev_d      = xprev_q;
    yprev_d      = yprev_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_ch_d     = out_ch_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          x_d          = bus.req_data[grant*DW +: DW];
          g_d          = grant;
          last_grant_d = grant;
          state_d      = CALC;
        end
      end
      CALC: begin
        xprev_d[g_q] = x_q;
        yprev_d[g_q] = y_sum;
        out_data_d   = y_sum;
        out_ch_d     = g_q;
        out_valid_d  = 1'b1;
        state_d      = OUT;
      end
      OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Clears are applied last so they override a same-cycle history write.
    for (int i = 0; i < NCH; i++) begin
      if (bus.clr_ch[i]) begin
        xprev_d[i] = '0;
        yprev_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= CW'(NCH - 1);
      g_q          <= '0;
      x_q          <= '0;
      for (int i = 0; i < NCH; i++) begin
        xprev_q[i] <= '0;
        yprev_q[i] <= '0;
      end
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_ch_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      g_q          <= g_d;
      x_q          <= x_d;
      xprev_q      <= xprev_d;
      yprev_q      <= yprev_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_ch_q     <= out_ch_d;
    end
  end

endmodule
